draw_engine: RTL

DRAW_ENGINE -- requirements
Module: draw_engine

---
 rtl/breakout_pkg.sv | 92 +++++++++
 rtl/rect_scan.sv | 50 +++++
 rtl/draw_engine.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/breakout_pkg.sv
// Shared constants, types and geometry helpers for the breakout video path.
// Everything here is fixed screen layout; the draw engine only decodes commands into rectangles.
package breakout_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int CODE_W   = 5;
  localparam int SIZE_X_W = 5;
  localparam int SIZE_Y_W = 3;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic [2:0] colour_t;

  localparam colour_t COL_BLACK  = 3'b000;
  localparam colour_t COL_RED    = 3'b100;
  localparam colour_t COL_YELLOW = 3'b110;
  localparam colour_t COL_GREEN  = 3'b010;
  localparam colour_t COL_WHITE  = 3'b111;

  localparam logic [X_W-1:0]      BRICK_X0 = 8'd16;
  localparam logic [Y_W-1:0]      BRICK_Y0 = 7'd8;
  localparam logic [SIZE_X_W-1:0] BRICK_W  = 5'd30;
  localparam logic [SIZE_Y_W-1:0] BRICK_H  = 3'd6;

  localparam logic [SIZE_X_W-1:0] PADDLE_W      = 5'd24;
  localparam logic [SIZE_Y_W-1:0] PADDLE_H      = 3'd3;
  localparam logic [Y_W-1:0]      PADDLE_Y      = 7'd112;
  localparam logic [X_W-1:0]      PADDLE_X_MAX  = 8'd136;
  localparam logic [X_W-1:0]      PADDLE_X_INIT = 8'd68;

  localparam logic [SIZE_X_W-1:0] BALL_W      = 5'd2;
  localparam logic [SIZE_Y_W-1:0] BALL_H      = 3'd2;
  localparam logic [X_W-1:0]      BALL_X_MAX  = 8'd158;
  localparam logic [Y_W-1:0]      BALL_Y_MAX  = 7'd118;
  localparam logic [X_W-1:0]      BALL_X_INIT = 8'd79;
  localparam logic [Y_W-1:0]      BALL_Y_INIT = 7'd60;

  localparam logic [CODE_W-1:0] CODE_IDLE         = 5'd0;
  localparam logic [CODE_W-1:0] CODE_BRICK_LAST   = 5'd12;
  localparam logic [CODE_W-1:0] CODE_ERASE_PADDLE = 5'd13;
  localparam logic [CODE_W-1:0] CODE_DRAW_PADDLE  = 5'd14;
  localparam logic [CODE_W-1:0] CODE_ERASE_BALL   = 5'd15;
  localparam logic [CODE_W-1:0] CODE_DRAW_BALL    = 5'd16;
  localparam logic [CODE_W-1:0] CODE_ERASE_FIRST  = 5'd17;
  localparam logic [CODE_W-1:0] CODE_VALID_LAST   = 5'd28;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAW, ST_DONE} state_t;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [SIZE_X_W-1:0] w;
    logic [SIZE_Y_W-1:0] h;
    colour_t             colour;
  } rect_t;

  function automatic logic is_draw_code(input logic [CODE_W-1:0] code);
    return (code != CODE_IDLE) && (code <= CODE_VALID_LAST);
  endfunction

  function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] v, input logic [X_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] v, input logic [Y_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // Bricks are a 4-wide grid; draw codes 1-12 and erase codes 17-28 map onto the same index.
  function automatic rect_t brick_rect(input logic [CODE_W-1:0] code);
    rect_t      r;
    logic [3:0] idx;
    logic       erase;
    erase = (code >= CODE_ERASE_FIRST);
    idx   = erase ? 4'(code - 5'd17) : 4'(code - 5'd1);
    r.x   = BRICK_X0 + {1'b0, idx[1:0], 5'd0};
    r.y   = BRICK_Y0 + {2'b00, idx[3:2], 3'd0};
    r.w   = BRICK_W;
    r.h   = BRICK_H;
    case (idx[3:2])
      2'd0:    r.colour = COL_RED;
      2'd1:    r.colour = COL_YELLOW;
      2'd2:    r.colour = COL_GREEN;
      default: r.colour = COL_BLACK;
    endcase
    if (erase) r.colour = COL_BLACK;
    return r;
  endfunction

endpackage

// File: rtl/rect_scan.sv
// Raster scanner: after a start pulse walks (cx, cy) row-major over a w x h rectangle,
// one position per cycle, flagging the final position with last.
module rect_scan
  import breakout_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [SIZE_X_W-1:0] w,
  input  logic [SIZE_Y_W-1:0] h,
  output logic [SIZE_X_W-1:0] cx,
  output logic [SIZE_Y_W-1:0] cy,
  output logic                valid,
  output logic                last
);

  logic [SIZE_X_W-1:0] w_q;
  logic [SIZE_Y_W-1:0] h_q;
  logic                row_end;

  assign row_end = (cx == w_q - 5'd1);
  assign last    = valid && row_end && (cy == h_q - 3'd1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_q   <= '0;
      h_q   <= '0;
      cx    <= '0;
      cy    <= '0;
      valid <= 1'b0;
    end else if (start) begin
      w_q   <= w;
      h_q   <= h;
      cx    <= '0;
      cy    <= '0;
      valid <= 1'b1;
    end else if (valid) begin
      if (last) begin
        valid <= 1'b0;
      end else if (row_end) begin
        cx <= '0;
        cy <= cy + 3'd1;
      end else begin
        cx <= cx + 5'd1;
      end
    end
  end

endmodule

// File: rtl/draw_engine.sv
// Breakout draw engine: decodes controller commands into rectangles and streams
// their pixels to the VGA adapter, one registered pixel per cycle.
module draw_engine
  import breakout_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [CODE_W-1:0] ld_draw,
  input  logic [X_W-1:0]    paddle_x,
  input  logic [X_W-1:0]    ball_x,
  input  logic [Y_W-1:0]    ball_y,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output colour_t           colour,
  output logic              plot,
  output logic              busy,
  output logic              done
);

  state_t              state;
  logic [CODE_W-1:0]   last_code;
  logic [X_W-1:0]      old_paddle_x;
  logic [X_W-1:0]      old_ball_x;
  logic [Y_W-1:0]      old_ball_y;
  rect_t               cmd_rect;
  rect_t               rect_q;
  logic                accept;
  logic                last_px;

  logic [SIZE_X_W-1:0] scan_cx;
  logic [SIZE_Y_W-1:0] scan_cy;
  logic                scan_valid;
  logic                scan_last;

  always_comb begin
    // NOTE: cmd_rect gets a full default before the case so no path leaves it unassigned (no latch).
    cmd_rect = brick_rect(ld_draw);
    case (ld_draw)
      CODE_ERASE_PADDLE: begin
        cmd_rect.x      = old_paddle_x;
        cmd_rect.y      = PADDLE_Y;
        cmd_rect.w      = PADDLE_W;
        cmd_rect.h      = PADDLE_H;
        cmd_rect.colour = COL_BLACK;
      end
      CODE_DRAW_PADDLE: begin
        cmd_rect.x      = clamp_x(paddle_x, PADDLE_X_MAX);
        cmd_rect.y      = PADDLE_Y;
        cmd_rect.w      = PADDLE_W;
        cmd_rect.h      = PADDLE_H;
        cmd_rect.colour = COL_WHITE;
      end
      CODE_ERASE_BALL: begin
        cmd_rect.x      = old_ball_x;
        cmd_rect.y      = old_ball_y;
        cmd_rect.w      = BALL_W;
        cmd_rect.h      = BALL_H;
        cmd_rect.colour = COL_BLACK;
      end
      CODE_DRAW_BALL: begin
        cmd_rect.x      = clamp_x(ball_x, BALL_X_MAX);
        cmd_rect.y      = clamp_y(ball_y, BALL_Y_MAX);
        cmd_rect.w      = BALL_W;
        cmd_rect.h      = BALL_H;
        cmd_rect.colour = COL_WHITE;
      end
      default: ;
    endcase
  end

  // A held code is only re-armed by passing through idle (code 0) first.
  assign accept = (state == ST_IDLE) && is_draw_code(ld_draw) && (ld_draw != last_code);

  // The scanner starts on the accept edge so its first position is ready while in LOAD.
  rect_scan u_scan (
    .clk    (clk),
    .resetn (resetn),
    .start  (accept),
    .w      (cmd_rect.w),
    .h      (cmd_rect.h),
    .cx     (scan_cx),
    .cy     (scan_cy),
    .valid  (scan_valid),
    .last   (scan_last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      last_code    <= '0;
      old_paddle_x <= PADDLE_X_INIT;
      old_ball_x   <= BALL_X_INIT;
      old_ball_y   <= BALL_Y_INIT;
      rect_q       <= '0;
      last_px      <= 1'b0;
      x            <= '0;
      y            <= '0;
      colour       <= COL_BLACK;
      plot         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ld_draw == CODE_IDLE) last_code <= '0;
          if (accept) begin
            state     <= ST_LOAD;
            busy      <= 1'b1;
            last_code <= ld_draw;
            rect_q    <= cmd_rect;
            if (ld_draw == CODE_DRAW_PADDLE) old_paddle_x <= cmd_rect.x;
            if (ld_draw == CODE_DRAW_BALL) begin
              old_ball_x <= cmd_rect.x;
              old_ball_y <= cmd_rect.y;
            end
          end
        end
        ST_LOAD: begin
          state  <= ST_DRAW;
          colour <= rect_q.colour;
          plot   <= scan_valid;
          if (scan_valid) begin
            x       <= rect_q.x + {3'b000, scan_cx};
            y       <= rect_q.y + {4'b0000, scan_cy};
            last_px <= scan_last;
          end
        end
        ST_DRAW: begin
          if (last_px) begin
            state   <= ST_DONE;
            plot    <= 1'b0;
            done    <= 1'b1;
            last_px <= 1'b0;
          end else begin
            plot <= scan_valid;
            if (scan_valid) begin
              x       <= rect_q.x + {3'b000, scan_cx};
              y       <= rect_q.y + {4'b0000, scan_cy};
              last_px <= scan_last;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
